// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the 8080 front end: opcode constants the sequencer
//   reacts to, the fetch FSM state encoding and the instruction length codes.
//   Optional feature macro used by the importing blocks: FETCH_INTR_EN.
package fetch_sequencer_pkg;

    localparam logic [7:0] OP_HLT = 8'h76;
    localparam logic [7:0] OP_EI  = 8'hFB;
    localparam logic [7:0] OP_DI  = 8'hF3;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LEN1 = 2'd1,
        LEN2 = 2'd2,
        LEN3 = 2'd3
    } len_t;

endpackage

// File: rtl/fetch_sequencer_op_len.sv
// op_len
//   Combinational 8080 instruction length decoder (1, 2 or 3 bytes).
//   Undocumented opcodes follow the silicon: CB is a JMP alias, DD/ED/FD are
//   CALL aliases, everything unlisted is a single byte.
// Ports:
//   opcode  in   8  first byte of the instruction
//   len     out  2  instruction length, 1..3
module op_len
    import fetch_sequencer_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    always_comb begin
        len = LEN1;
        casez (opcode)
            8'b00??_?110,                         // MVI
            8'b11??_?110,                         // immediate ALU ops
            8'hD3, 8'hDB:                         // OUT, IN
                len = LEN2;
            8'b00??_0001,                         // LXI
            8'h22, 8'h2A, 8'h32, 8'h3A,           // SHLD, LHLD, STA, LDA
            8'hC3, 8'hCB,                         // JMP and alias
            8'b11??_?010,                         // Jcc
            8'b11??_?100,                         // Ccc
            8'hCD, 8'hDD, 8'hED, 8'hFD:           // CALL and aliases
                len = LEN3;
            default:
                len = LEN1;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Front-end controller: owns the PC, fetches a 24-bit window per
//   instruction, sizes it and hands it to decode over valid/ready. Redirects
//   from execute override the handshake; HLT parks the front end.
//   Optional macro FETCH_INTR_EN adds interrupt entry (RST n injection).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fetch_addr  out 16  memory address (always pc)
//   fetch_data  in  24  {opcode, lo, hi}, valid one cycle after address
//   d_valid/d_ready     decode handshake
//   d_instr     out 24  instruction window
//   d_pc        out 16  address of presented instruction
//   d_len       out  2  instruction length
//   d_next_pc   out 16  d_pc + d_len (return address for CALL/RST)
//   redirect_valid/pc   execute-driven PC change
//   halted      out  1  parked after HLT
//   intr_req/intr_vec/intr_ack   (FETCH_INTR_EN only)
//
// state | meaning
// FETCH | address presented, waiting one cycle for fetch_data
// VALID | instruction presented to decode, waiting for d_ready
// HALT  | parked after HLT, pc frozen
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] fetch_addr,
    input  logic [23:0] fetch_data,
    output logic        d_valid,
    output logic [23:0] d_instr,
    output logic [15:0] d_pc,
    output logic [1:0]  d_len,
    output logic [15:0] d_next_pc,
    input  logic        d_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        halted
`ifdef FETCH_INTR_EN
    ,
    input  logic        intr_req,
    input  logic [2:0]  intr_vec,
    output logic        intr_ack
`endif
);

    state_t      state;
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic [1:0]  fetch_len;

    assign opcode = fetch_data[23:16];

    op_len u_op_len (
        .opcode (opcode),
        .len    (fetch_len)
    );

    assign fetch_addr = pc;
    assign d_pc       = pc;

`ifdef FETCH_INTR_EN
    logic       ie;
    logic       intr_sel;   // VALID is presenting a synthesized RST
    logic [2:0] intr_vec_q;
    logic       take_intr;

    assign take_intr = ie && intr_req && !redirect_valid;

    // The synthesized RST must not advance the return address.
    assign d_instr   = intr_sel ? {2'b11, intr_vec_q, 3'b111, 16'h0000} : fetch_data;
    assign d_len     = intr_sel ? 2'd1 : fetch_len;
    assign d_next_pc = intr_sel ? pc : pc + {14'd0, d_len};
`else
    assign d_instr   = fetch_data;
    assign d_len     = fetch_len;
    assign d_next_pc = pc + {14'd0, d_len};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            d_valid <= 1'b0;
            halted  <= 1'b0;
`ifdef FETCH_INTR_EN
            ie         <= 1'b0;
            intr_sel   <= 1'b0;
            intr_vec_q <= 3'd0;
            intr_ack   <= 1'b0;
`endif
        end else begin
`ifdef FETCH_INTR_EN
            intr_ack <= 1'b0;
`endif
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
`ifdef FETCH_INTR_EN
                    end else if (take_intr) begin
                        state      <= VALID;
                        d_valid    <= 1'b1;
                        intr_sel   <= 1'b1;
                        intr_vec_q <= intr_vec;
                        intr_ack   <= 1'b1;
                        ie         <= 1'b0;
`endif
                    end else begin
                        state   <= VALID;
                        d_valid <= 1'b1;
`ifdef FETCH_INTR_EN
                        intr_sel <= 1'b0;
`endif
                    end
                end
                VALID: begin
                    if (redirect_valid) begin
                        pc      <= redirect_pc;
                        state   <= FETCH;
                        d_valid <= 1'b0;
                    end else if (d_ready) begin
                        pc      <= d_next_pc;
                        d_valid <= 1'b0;
`ifdef FETCH_INTR_EN
                        intr_sel <= 1'b0;
                        if (!intr_sel && opcode == OP_EI) ie <= 1'b1;
                        if (!intr_sel && opcode == OP_DI) ie <= 1'b0;
                        if (!intr_sel && opcode == OP_HLT) begin
`else
                        if (opcode == OP_HLT) begin
`endif
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
`ifdef FETCH_INTR_EN
                    if (take_intr) begin
                        state      <= VALID;
                        d_valid    <= 1'b1;
                        halted     <= 1'b0;
                        intr_sel   <= 1'b1;
                        intr_vec_q <= intr_vec;
                        intr_ack   <= 1'b1;
                        ie         <= 1'b0;
                    end
`endif
                end
                default: begin
                    state   <= FETCH;
                    d_valid <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fetch_addr;
    logic [23:0] fetch_data;
    logic        d_valid;
    logic [23:0] d_instr;
    logic [15:0] d_pc;
    logic [1:0]  d_len;
    logic [15:0] d_next_pc;
    logic        d_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
`ifdef FETCH_INTR_EN
    logic        intr_req;
    logic [2:0]  intr_vec;
    logic        intr_ack;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [65536];
    logic [15:0] a1, a2;

    always #5 clk = ~clk;

    assign a1 = fetch_addr + 16'd1;
    assign a2 = fetch_addr + 16'd2;

    always_ff @(posedge clk)
        fetch_data <= {mem[fetch_addr], mem[a1], mem[a2]};

    fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .d_valid        (d_valid),
        .d_instr        (d_instr),
        .d_pc           (d_pc),
        .d_len          (d_len),
        .d_next_pc      (d_next_pc),
        .d_ready        (d_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef FETCH_INTR_EN
        ,
        .intr_req       (intr_req),
        .intr_vec       (intr_vec),
        .intr_ack       (intr_ack)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h3E; mem[16'h0001] = 8'h41;
        mem[16'h0002] = 8'hC3; mem[16'h0003] = 8'h00; mem[16'h0004] = 8'h10;
        mem[16'h0010] = 8'h21; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
        mem[16'h0100] = 8'h76;
        mem[16'hFFFE] = 8'h01; mem[16'hFFFF] = 8'h55;
        mem[16'h01FF] = 8'hFB; mem[16'h0200] = 8'h76;

        rst = 1'b1; d_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
`ifdef FETCH_INTR_EN
        intr_req = 1'b0; intr_vec = 3'd0;
`endif
        step(); step();
        check("rst_valid",  d_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_addr",   fetch_addr, 16'h0000);
        rst = 1'b0;

        // 1: sequential flow, one instruction every two cycles
        step();
        check("t1_v0",    d_valid, 1);
        check("t1_pc0",   d_pc, 16'h0000);
        check("t1_len0",  d_len, 2);
        check("t1_ins0",  d_instr, 24'h3E41C3);
        step();
        check("t1_gap0",  d_valid, 0);
        step();
        check("t1_pc1",   d_pc, 16'h0002);
        check("t1_len1",  d_len, 3);
        check("t1_ins1",  d_instr, 24'hC30010);
        check("t1_nxt1",  d_next_pc, 16'h0005);
        step();
        check("t1_gap1",  d_valid, 0);
        step();
        check("t1_v2",    d_valid, 1);
        check("t1_pc2",   d_pc, 16'h0005);
        check("t1_len2",  d_len, 1);

        // 2: stall in VALID at 0x0010
        redirect_valid = 1'b1; redirect_pc = 16'h0010; d_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        check("t2_redir_gap", d_valid, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_v",    d_valid, 1);
            check("t2_hold_pc",   d_pc, 16'h0010);
            check("t2_hold_ins",  d_instr, 24'h213412);
            check("t2_hold_addr", fetch_addr, 16'h0010);
            step();
        end
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        check("t2_adv_addr", fetch_addr, 16'h0013);
        step();
        check("t2_adv_pc", d_pc, 16'h0013);

        // 3: redirect beats a same-cycle handshake
        redirect_valid = 1'b1; redirect_pc = 16'h0002;
        step();
        redirect_valid = 1'b0; d_ready = 1'b1;
        step();
        check("t3_pc2", d_pc, 16'h0002);
        redirect_valid = 1'b1; redirect_pc = 16'h1234;
        step();
        redirect_valid = 1'b0;
        check("t3_addr", fetch_addr, 16'h1234);
        check("t3_gap",  d_valid, 0);
        step();
        check("t3_v",    d_valid, 1);
        check("t3_pc",   d_pc, 16'h1234);

        // 5: wrap at the top of memory
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        step();
        check("t5_pc",   d_pc, 16'hFFFE);
        check("t5_len",  d_len, 3);
        check("t5_ins",  d_instr, 24'h01553E);
        check("t5_nxt",  d_next_pc, 16'h0001);
        step();
        check("t5_addr", fetch_addr, 16'h0001);

        // 4: HLT parks the front end, redirects ignored, rst recovers
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect_valid = 1'b0;
        step();
        check("t4_op",     d_instr[23:16], 8'h76);
        check("t4_len",    d_len, 1);
        step();
        check("t4_halted", halted, 1);
        check("t4_addr",   fetch_addr, 16'h0101);
        redirect_valid = 1'b1; redirect_pc = 16'h2000;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t4_park_v", d_valid, 0);
            check("t4_park_h", halted, 1);
        end
        check("t4_park_addr", fetch_addr, 16'h0101);
        redirect_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_rst_addr", fetch_addr, 16'h0000);
        check("t4_rst_h",    halted, 0);
        check("t4_rst_v",    d_valid, 0);

`ifdef FETCH_INTR_EN
        // 6: EI, HLT, then interrupt entry with vector 7
        redirect_valid = 1'b1; redirect_pc = 16'h01FF;
        step();
        redirect_valid = 1'b0;
        step();
        check("t6_ei", d_instr[23:16], 8'hFB);
        step(); step();
        check("t6_hlt", d_instr[23:16], 8'h76);
        step();
        check("t6_halted", halted, 1);
        intr_req = 1'b1; intr_vec = 3'd7;
        step();
        check("t6_ins",  d_instr, 24'hFF0000);
        check("t6_pc",   d_pc, 16'h0201);
        check("t6_nxt",  d_next_pc, 16'h0201);
        check("t6_len",  d_len, 1);
        check("t6_ack",  intr_ack, 1);
        check("t6_h",    halted, 0);
        step();
        check("t6_ack_drop", intr_ack, 0);
        step();
        check("t6_noint_ins", d_instr, 24'h000000);
        check("t6_noint_pc",  d_pc, 16'h0201);
        check("t6_noint_ack", intr_ack, 0);
        intr_req = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
